// File: rtl/guitarpedal_pkg.sv
// Shared types and constants for the guitar pedal datapath: gate states and the
// Q1.8 gain format with its saturating ramp helpers.
package guitarpedal_pkg;

    localparam int unsigned GAIN_W    = 9;
    localparam int unsigned GAIN_FRAC = 8;
    localparam logic [GAIN_W-1:0] GAIN_ONE = 9'd256;

    typedef enum logic [2:0] {
        GATE_CLOSED  = 3'd0,
        GATE_OPENING = 3'd1,
        GATE_OPEN    = 3'd2,
        GATE_HOLD    = 3'd3,
        GATE_CLOSING = 3'd4
    } gate_state_e;

    function automatic logic [GAIN_W-1:0] gain_ramp_up(input logic [GAIN_W-1:0] gain,
                                                       input logic [GAIN_W-1:0] step);
        logic [GAIN_W:0] sum;
        sum = {1'b0, gain} + {1'b0, step};
        if (sum >= {1'b0, GAIN_ONE}) begin
            return GAIN_ONE;
        end
        return sum[GAIN_W-1:0];
    endfunction

    function automatic logic [GAIN_W-1:0] gain_ramp_down(input logic [GAIN_W-1:0] gain,
                                                         input logic [GAIN_W-1:0] step);
        if (step >= gain) begin
            return '0;
        end
        return gain - step;
    endfunction

endpackage

// File: rtl/env_follower.sv
// One-pole envelope follower with separate attack and release exponents.
// env_n is the combinational next value so the gate can decide on the same beat.
module env_follower #(
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_mag,
    input  logic [4:0]       attack_shift,
    input  logic [4:0]       release_shift,
    output logic [WIDTH-1:0] env_n,
    output logic [WIDTH-1:0] env
);

    logic [WIDTH-1:0] env_q;
    logic [WIDTH:0]   mag_x;
    logic [WIDTH:0]   env_x;
    logic [WIDTH:0]   delta;
    logic [WIDTH:0]   delta_sh;
    logic [WIDTH:0]   env_nx;
    logic             unused_env_msb;

    always_comb begin
        mag_x    = {1'b0, in_mag};
        env_x    = {1'b0, env_q};
        delta    = '0;
        delta_sh = '0;
        env_nx   = env_x;
        if (mag_x > env_x) begin
            delta    = mag_x - env_x;
            delta_sh = delta >> attack_shift;
            env_nx   = env_x + delta_sh;
        end else begin
            delta    = env_x - mag_x;
            delta_sh = delta >> release_shift;
            env_nx   = env_x - delta_sh;
        end
    end

    // Result always lies between env and in_mag, so the extra bit is never set.
    assign env_n          = env_nx[WIDTH-1:0];
    assign unused_env_msb = env_nx[WIDTH];
    assign env            = env_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            env_q <= '0;
        end else if (in_valid) begin
            env_q <= env_n;
        end
    end

endmodule

// File: rtl/envelope_gate.sv
// Noise gate: envelope-driven hysteresis FSM with hold time and a linear gain ramp,
// applied to the audio sample through a two-stage pipeline.
module envelope_gate
    import guitarpedal_pkg::*;
#(
    parameter int unsigned WIDTH  = 24,
    parameter int unsigned HOLD_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_sample,
    input  logic [WIDTH-1:0]        in_mag,
    input  logic [4:0]              attack_shift,
    input  logic [4:0]              release_shift,
    input  logic [WIDTH-1:0]        thresh_open,
    input  logic [WIDTH-1:0]        thresh_close,
    input  logic [HOLD_W-1:0]       hold_samples,
    input  logic [7:0]              ramp_step,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_sample,
    output logic [WIDTH-1:0]        env,
    output logic                    gate_open
);

    localparam int unsigned PROD_W = WIDTH + GAIN_W + 1;

    logic [WIDTH-1:0]        env_n;
    gate_state_e             state_q;
    gate_state_e             state_d;
    logic [GAIN_W-1:0]       gain_q;
    logic [GAIN_W-1:0]       gain_d;
    logic [GAIN_W-1:0]       step;
    logic [GAIN_W-1:0]       gain_up;
    logic [GAIN_W-1:0]       gain_dn;
    logic [HOLD_W-1:0]       hold_q;
    logic [HOLD_W-1:0]       hold_d;
    logic signed [WIDTH-1:0] sample_q;
    logic                    s1_valid_q;
    logic                    open_hit;
    logic                    close_hit;
    logic signed [PROD_W-1:0] sample_ext;
    logic signed [PROD_W-1:0] gain_ext;
    logic signed [PROD_W-1:0] product;
    logic                    unused_product;

    env_follower #(
        .WIDTH(WIDTH)
    ) u_env_follower (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_mag       (in_mag),
        .attack_shift (attack_shift),
        .release_shift(release_shift),
        .env_n        (env_n),
        .env          (env)
    );

    assign step      = (ramp_step == 8'd0) ? 9'd1 : {1'b0, ramp_step};
    assign gain_up   = gain_ramp_up(gain_q, step);
    assign gain_dn   = gain_ramp_down(gain_q, step);
    assign open_hit  = (env_n >= thresh_open);
    assign close_hit = (env_n < thresh_close);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            GATE_CLOSED: begin
                if (open_hit) state_d = GATE_OPENING;
            end
            GATE_OPENING: begin
                if (close_hit) begin
                    state_d = GATE_CLOSING;
                end else if (gain_up == GAIN_ONE) begin
                    state_d = GATE_OPEN;
                end
            end
            GATE_OPEN: begin
                if (close_hit) begin
                    state_d = GATE_HOLD;
                    hold_d  = hold_samples;
                end
            end
            GATE_HOLD: begin
                if (open_hit) begin
                    state_d = GATE_OPEN;
                end else if (hold_q == '0) begin
                    state_d = GATE_CLOSING;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            GATE_CLOSING: begin
                if (open_hit) begin
                    state_d = GATE_OPENING;
                end else if (gain_dn == '0) begin
                    state_d = GATE_CLOSED;
                end
            end
            default: state_d = GATE_CLOSED;
        endcase
    end

    // Gain follows the state the beat lands in, so the final ramp step is the
    // one that completes the transition into OPEN or CLOSED.
    always_comb begin
        gain_d = gain_q;
        unique case (state_d)
            GATE_OPENING: gain_d = gain_up;
            GATE_CLOSING: gain_d = gain_dn;
            GATE_OPEN:    gain_d = (state_q == GATE_OPENING) ? gain_up : gain_q;
            GATE_CLOSED:  gain_d = (state_q == GATE_CLOSING) ? gain_dn : gain_q;
            GATE_HOLD:    gain_d = gain_q;
            default:      gain_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= GATE_CLOSED;
            gain_q     <= '0;
            hold_q     <= '0;
            sample_q   <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                state_q  <= state_d;
                gain_q   <= gain_d;
                hold_q   <= hold_d;
                sample_q <= in_sample;
            end
        end
    end

    assign sample_ext = $signed({{(GAIN_W + 1){sample_q[WIDTH-1]}}, sample_q});
    assign gain_ext   = $signed({{(WIDTH + 1){1'b0}}, gain_q});
    assign product    = sample_ext * gain_ext;
    // Taking the bits above the fraction is the arithmetic shift; exact at unity gain.
    assign unused_product = ^{product[PROD_W-1:WIDTH+GAIN_FRAC], product[GAIN_FRAC-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_sample <= '0;
        end else begin
            out_valid <= s1_valid_q;
            if (s1_valid_q) begin
                out_sample <= product[WIDTH+GAIN_FRAC-1:GAIN_FRAC];
            end
        end
    end

    assign gate_open = (state_q == GATE_OPENING) || (state_q == GATE_OPEN) ||
                       (state_q == GATE_HOLD);

endmodule

// File: tb/tb_envelope_gate.sv
// Bench for envelope_gate: directed vector table, hand-written reset sequences and
// randomized beats checked against a behavioural model of the gate.
module tb_envelope_gate;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic signed [23:0] in_sample;
    logic [23:0]        in_mag;
    logic [4:0]         attack_shift;
    logic [4:0]         release_shift;
    logic [23:0]        thresh_open;
    logic [23:0]        thresh_close;
    logic [15:0]        hold_samples;
    logic [7:0]         ramp_step;
    logic               out_valid;
    logic signed [23:0] out_sample;
    logic [23:0]        env;
    logic               gate_open;

    int n_checks = 0;
    int n_fail   = 0;

    envelope_gate #(
        .WIDTH (24),
        .HOLD_W(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_sample    (in_sample),
        .in_mag       (in_mag),
        .attack_shift (attack_shift),
        .release_shift(release_shift),
        .thresh_open  (thresh_open),
        .thresh_close (thresh_close),
        .hold_samples (hold_samples),
        .ramp_step    (ramp_step),
        .out_valid    (out_valid),
        .out_sample   (out_sample),
        .env          (env),
        .gate_open    (gate_open)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic signed [63:0] act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic set_cfg(input int a, input int r, input int topen, input int tclose,
                           input int hold, input int step);
        attack_shift  = a[4:0];
        release_shift = r[4:0];
        thresh_open   = topen[23:0];
        thresh_close  = tclose[23:0];
        hold_samples  = hold[15:0];
        ramp_step     = step[7:0];
    endtask

    // Entered and left at posedge+1; strobe, then two idle cycles.
    task automatic beat(input string tag, input int mag, input int smp, input bit exp_gate,
                        input longint exp_env, input longint exp_out);
        in_mag    = mag[23:0];
        in_sample = smp[23:0];
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check($sformatf("%s out_valid+1", tag), 64'(out_valid), 0);
        check($sformatf("%s gate_open", tag), 64'(gate_open), longint'(exp_gate));
        check($sformatf("%s env", tag), 64'(env), exp_env);
        @(posedge clk); #1;
        check($sformatf("%s out_valid+2", tag), 64'(out_valid), 1);
        check($sformatf("%s out_sample", tag), 64'(out_sample), exp_out);
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check($sformatf("%s out_valid", tag), 64'(out_valid), 0);
        check($sformatf("%s out_sample", tag), 64'(out_sample), 0);
        check($sformatf("%s env", tag), 64'(env), 0);
        check($sformatf("%s gate_open", tag), 64'(gate_open), 0);
    endtask

    task automatic do_reset(input string tag);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero(tag);
        rst = 1'b0;
    endtask

    // Asynchronous pulse between clock edges.
    task automatic mid_reset(input string tag);
        rst = 1'b1;
        #2;
        check_all_zero(tag);
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Behavioural reference: gate phases 0 closed, 1 opening, 2 open, 3 hold, 4 closing.
    longint m_env;
    int     m_phase;
    int     m_gain;
    longint m_hold;

    function automatic void model_reset();
        m_env = 0; m_phase = 0; m_gain = 0; m_hold = 0;
    endfunction

    function automatic void model_beat(input longint mag, input longint smp, input int a,
                                       input int r, input longint topen, input longint tclose,
                                       input longint hold, input int step_in,
                                       output bit gate, output longint e, output longint o);
        int s, up, dn, nxt;
        s  = (step_in == 0) ? 1 : step_in;
        up = (m_gain + s > 256) ? 256 : m_gain + s;
        dn = (m_gain - s < 0) ? 0 : m_gain - s;
        if (mag > m_env) m_env = m_env + ((mag - m_env) >> a);
        else             m_env = m_env - ((m_env - mag) >> r);
        nxt = m_phase;
        if (m_phase == 0) begin
            if (m_env >= topen) nxt = 1;
        end else if (m_phase == 1) begin
            if (m_env < tclose) nxt = 4;
            else if (up == 256) nxt = 2;
        end else if (m_phase == 2) begin
            if (m_env < tclose) begin nxt = 3; m_hold = hold; end
        end else if (m_phase == 3) begin
            if (m_env >= topen) nxt = 2;
            else if (m_hold == 0) nxt = 4;
            else m_hold = m_hold - 1;
        end else begin
            if (m_env >= topen) nxt = 1;
            else if (dn == 0) nxt = 0;
        end
        if (nxt == 1) m_gain = up;
        else if (nxt == 4) m_gain = dn;
        else if (nxt == 2) m_gain = 256;
        else if (nxt == 0) m_gain = 0;
        m_phase = nxt;
        gate = (nxt == 1) || (nxt == 2) || (nxt == 3);
        e = m_env;
        o = (smp * m_gain) >>> 8;
    endfunction

    typedef struct {
        int  mag;
        int  smp;
        bit  gate;
        int  env;
        int  out;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input int mag, input int smp, input bit g, input int e,
                                    input int o);
        vec_t v;
        v.mag = mag; v.smp = smp; v.gate = g; v.env = e; v.out = o;
        vecs.push_back(v);
    endfunction

    initial begin
        int min_s;
        logic signed [23:0] s24;
        min_s = -8388608;
        rst = 1'b1;
        in_valid = 1'b0;
        in_sample = '0;
        in_mag = '0;
        set_cfg(0, 0, 1000, 500, 3, 64);

        // Quiet input, ramp open, hold, ramp closed, re-open from hold, full-scale negative.
        for (int i = 0; i < 10; i++) add_vec(0, 1234, 0, 0, 0);
        add_vec(5000, 4000, 1, 5000, 1000);
        add_vec(5000, 4000, 1, 5000, 2000);
        add_vec(5000, 4000, 1, 5000, 3000);
        add_vec(5000, 4000, 1, 5000, 4000);
        for (int i = 0; i < 4; i++) add_vec(0, 4000, 1, 0, 4000);
        add_vec(0, 4000, 0, 0, 3000);
        add_vec(0, 4000, 0, 0, 2000);
        add_vec(0, 4000, 0, 0, 1000);
        add_vec(0, 4000, 0, 0, 0);
        add_vec(0, 4000, 0, 0, 0);
        add_vec(5000, 4000, 1, 5000, 1000);
        add_vec(5000, 4000, 1, 5000, 2000);
        add_vec(5000, 4000, 1, 5000, 3000);
        add_vec(5000, 4000, 1, 5000, 4000);
        add_vec(0, 4000, 1, 0, 4000);
        add_vec(0, 4000, 1, 0, 4000);
        add_vec(5000, 4000, 1, 5000, 4000);
        add_vec(5000, min_s, 1, 5000, min_s);

        do_reset("reset");
        foreach (vecs[i]) begin
            beat($sformatf("vec%0d", i), vecs[i].mag, vecs[i].smp, vecs[i].gate,
                 vecs[i].env, vecs[i].out);
        end

        // Reset mid-ramp at gain 128, then restart from a zero envelope.
        do_reset("reset2");
        beat("ramp64", 5000, 4000, 1, 5000, 1000);
        beat("ramp128_min", 5000, min_s, 1, 5000, -4194304);
        mid_reset("midramp_rst");
        set_cfg(1, 0, 1000, 500, 3, 64);
        beat("after_rst", 5000, 4000, 1, 2500, 1000);
        set_cfg(0, 0, 1000, 500, 3, 64);

        // Reset while a sample sits in the pipeline: its output must never appear.
        in_mag = 24'd5000;
        in_sample = 24'd4000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #2;
        check("pipe_rst gate_open", 64'(gate_open), 0);
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        check("pipe_rst out_valid", 64'(out_valid), 0);
        check("pipe_rst out_sample", 64'(out_sample), 0);
        @(posedge clk); #1;
        beat("first_after_rst", 5000, 4000, 1, 5000, 1000);

        // Randomized beats against the model.
        do_reset("reset3");
        model_reset();
        for (int i = 0; i < 300; i++) begin
            int a, r, topen, tclose, hold, step, mag, smp;
            bit g;
            longint e, o;
            a      = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 23) : $urandom_range(0, 4);
            r      = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 23) : $urandom_range(0, 4);
            topen  = $urandom_range(0, 20000);
            tclose = ($urandom_range(0, 7) == 0) ? topen : $urandom_range(0, topen);
            hold   = $urandom_range(0, 4);
            step   = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 255);
            if ($urandom_range(0, 3) == 0)       mag = 0;
            else if ($urandom_range(0, 19) == 0) mag = $urandom_range(0, 24'hFFFFFF);
            else                                 mag = $urandom_range(0, 30000);
            s24 = 24'($urandom);
            smp = int'(s24);
            set_cfg(a, r, topen, tclose, hold, step);
            model_beat(mag, smp, a, r, topen, tclose, hold, step, g, e, o);
            beat($sformatf("rnd%0d", i), mag, smp, g, e, o);
            if (i % 97 == 50) begin
                mid_reset($sformatf("rnd_rst%0d", i));
                model_reset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/envelope_gate.md
ENVELOPE_GATE -- requirements
Module: envelope_gate

Interface
REQ-001 Parameter WIDTH, default 24, sample and magnitude width in bits.
REQ-002 Parameter HOLD_W, default 16, hold counter width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  one-cycle strobe per audio sample; at least 2 idle cycles between strobes.
REQ-006 in_sample  input  WIDTH  signed two's-complement audio, qualified by in_valid.
REQ-007 in_mag  input  WIDTH  unsigned magnitude of the same sample, produced by the upstream rectifier stage.
REQ-008 attack_shift, release_shift  input  5 each  one-pole coefficient exponents, range 0..23.
REQ-009 thresh_open, thresh_close  input  WIDTH each  unsigned hysteresis thresholds; thresh_close <= thresh_open.
REQ-010 hold_samples  input  HOLD_W  samples to stay open after the envelope drops.
REQ-011 ramp_step  input  8  gain increment/decrement per sample; 0 is treated as 1.
REQ-012 out_valid  output  1  strobe, exactly 2 cycles after in_valid.
REQ-013 out_sample  output  WIDTH  signed gated sample.
REQ-014 env  output  WIDTH  current envelope, unsigned.
REQ-015 gate_open  output  1  high in OPENING, OPEN, HOLD.

Function
REQ-016 Config inputs are sampled only on in_valid cycles; changes between strobes are legal.
REQ-017 On in_valid, if in_mag > env: env <= env + ((in_mag - env) >> attack_shift); else env <= env - ((env - in_mag) >> release_shift); unsigned, WIDTH+1-bit intermediates, no overflow possible.
REQ-018 State machine CLOSED, OPENING, OPEN, HOLD, CLOSING; transitions only on in_valid, evaluated against updated env (env_n).
REQ-019 CLOSED: env_n >= thresh_open -> OPENING.
REQ-020 OPENING: env_n < thresh_close -> CLOSING; else if gain reaches 256 -> OPEN.
REQ-021 OPEN: env_n < thresh_close -> HOLD, hold counter loaded with hold_samples.
REQ-022 HOLD: env_n >= thresh_open -> OPEN; else counter == 0 -> CLOSING; else counter decrements by 1.
REQ-023 CLOSING: env_n >= thresh_open -> OPENING; else gain reaches 0 -> CLOSED.
REQ-024 Gain is 9-bit unsigned 0..256; in OPENING gain += ramp_step saturating at 256; in CLOSING gain -= ramp_step saturating at 0; held in other states; update uses the next state of the same beat.
REQ-025 Stage 1 (in_valid cycle +1): env, state, gain, sample registered; stage 2 (+2): out_sample = (sample * gain) >>> 8, arithmetic, exact for gain 256, registered with out_valid.
REQ-026 out_sample is bit-exact passthrough at gain 256 and exactly 0 at gain 0.
REQ-027 Thresholds equal (thresh_open == thresh_close) give no hysteresis but remain legal.

Reset
REQ-028 rst asserted at any time, including mid-ramp or mid-hold, forces within the same cycle: state CLOSED, env 0, gain 0, hold counter 0, pipeline cleared, out_valid 0, out_sample 0, gate_open 0.
REQ-029 The first in_valid after rst deassertion is processed normally.

Structure
REQ-030 Package guitarpedal_pkg holds the gate_state_e enum, GAIN_ONE = 256 and GAIN_W = 9.
REQ-031 Sub-module env_follower (REQ-017 only, registered env) is instantiated once; FSM, gain ramp and multiply stay in envelope_gate.

Verification
REQ-032 Reset, 10 strobes with in_mag 0 -> env 0, gate_open 0, out_sample 0.
REQ-033 attack_shift 0, thresh_open 1000, in_mag 5000, in_sample 4000, ramp_step 64 -> gate_open on first beat; gains 64, 128, 192, 256; out_sample 1000, 2000, 3000, 4000, each 2 cycles after in_valid.
REQ-034 Gate open, release_shift 0, thresh_close 500, hold_samples 3, in_mag drops to 0 -> HOLD for 3 beats, then CLOSING, gain falls by ramp_step per beat to 0, CLOSED.
REQ-035 In HOLD, counter 2, in_mag returns to 5000 -> OPEN, gain stays 256, no dip in out_sample.
REQ-036 rst pulsed mid-OPENING at gain 128 -> all outputs 0 that cycle; next strobe restarts from CLOSED with env 0.
REQ-037 in_sample -8388608 at gain 256 -> out_sample -8388608; at gain 128 -> -4194304.
